csa_resolve: RTL and testbench

- Downstream stage of the carry-save adder: takes one redundant (sum, carry) vector pair and resolves it into a plain binary result.
- Uses a multi-cycle chunked ripple carry-propagate add, CHUNK bits per clock.
- Valid/ready handshake on both sides, so it can sit between a CSA tree and any consumer.
- Carry vector bit i has weight 2^(i+1), as produced by a CSA; result = sum_in + (carry_in << 1).

---
 rtl/csa_resolve.sv | 132 +++++++++++++
 tb/tb_csa_resolve.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve.sv
// Resolves a CSA (sum, carry) pair into binary with a chunked ripple add, CHUNK bits per cycle.
// Optional: define CSA_RESOLVE_EARLY_EXIT_EN to finish as soon as the remaining operand bits are zero.
module csa_resolve #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic [WIDTH-1:0] carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] result,
  output logic             busy
);

  localparam int unsigned XW    = WIDTH + 2;
  localparam int unsigned STEPS = XW / CHUNK;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if ((XW % CHUNK) != 0) begin : g_chunk_check
      $error("csa_resolve: CHUNK must divide WIDTH+2");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [XW-1:0]    r_s;
  logic [XW-1:0]    r_c;
  logic [XW-1:0]    r_res;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK-1:0] w_s_chk;
  logic [CHUNK-1:0] w_c_chk;
  logic [CHUNK-1:0] w_sum;
  logic             w_cout;
  logic [XW-1:0]    w_res_nxt;
  logic             w_last;

  // Chunk selection is unrolled so every slice index stays constant.
  always_comb begin
    w_s_chk = '0;
    w_c_chk = '0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_s_chk = r_s[k*CHUNK +: CHUNK];
        w_c_chk = r_c[k*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    {w_cout, w_sum} = {1'b0, w_s_chk} + {1'b0, w_c_chk} + {{CHUNK{1'b0}}, r_cy};
  end

  always_comb begin
    w_res_nxt = r_res;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_res_nxt[k*CHUNK +: CHUNK] = w_sum;
      end
    end
  end

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
  logic w_hi_zero;

  always_comb begin
    w_hi_zero = 1'b0;
    for (int unsigned k = 0; k < STEPS; k++) begin
      if (r_cnt == CW'(k)) begin
        w_hi_zero = (((r_s | r_c) >> ((k + 1) * CHUNK)) == '0);
      end
    end
  end

  assign w_last = (r_cnt == CW'(STEPS - 1)) || (w_hi_zero && !w_cout);
`else
  assign w_last = (r_cnt == CW'(STEPS - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_c     <= '0;
      r_res   <= '0;
      r_cy    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_s     <= {2'b00, sum_in};
            r_c     <= {1'b0, carry_in, 1'b0};
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_res <= w_res_nxt;
          r_cy  <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == BUSY);
  assign out_valid = (r_state == DONE);
  assign result    = r_res;

endmodule

// File: tb/tb_csa_resolve.sv
// Randomized self-checking bench for csa_resolve (default build and a CHUNK=3 instance).
module tb_csa_resolve;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] sum_in, carry_in;
  logic       in_ready, out_valid, busy;
  logic [5:0] result;

  logic       v3, or3;
  logic [3:0] s3, c3;
  logic       rdy3, ov3, busy3;
  logic [5:0] res3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_resolve #(.WIDTH(4), .CHUNK(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  csa_resolve #(.WIDTH(4), .CHUNK(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3),
    .sum_in(s3), .carry_in(c3), .out_valid(ov3),
    .out_ready(or3), .result(res3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Edges from accept to out_valid, from the arithmetic definition of the exit rule.
  function automatic int exp_lat(input int s, input int c, input int chunk, input int steps);
    int se, ce, m;
    se = s;
    ce = c * 2;
    m  = 0;
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
    for (int j = 1; j <= steps; j++) begin
      m = 1 << (j * chunk);
      if (((se | ce) >> (j * chunk)) == 0 && ((se % m) + (ce % m)) < m) return j;
    end
`endif
    return steps + (m * 0);
  endfunction

  task automatic complete_op(input int s, input int c, input int hold);
    int lat, exp;
    exp = s + 2 * c;
    in_valid = 1'($urandom);
    sum_in   = 4'($urandom);
    carry_in = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_run", busy, 1);
      check("in_ready_busy", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat(s, c, 1, 6));
    check("result", result, exp);
    check("final_carry", dut.r_cy, 0);
    check("busy_done", busy, 0);
    repeat (hold) begin
      in_valid = 1'b1;
      sum_in   = 4'($urandom);
      carry_in = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_in_ready", in_ready, 1);
    check("drain_result", result, exp);
  endtask

  task automatic run_op(input int s, input int c, input int hold);
    @(negedge clk);
    sum_in   = 4'(s);
    carry_in = 4'(c);
    in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    complete_op(s, c, hold);
  endtask

  task automatic run_op3(input int s, input int c);
    int lat;
    @(negedge clk);
    s3 = 4'(s);
    c3 = 4'(c);
    v3 = 1'b1;
    check("c3_in_ready", rdy3, 1);
    @(posedge clk); #1;
    v3 = 1'b0;
    s3 = 4'($urandom);
    c3 = 4'($urandom);
    lat = 0;
    while (!ov3 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("c3_latency", lat, exp_lat(s, c, 3, 2));
    check("c3_result", res3, s + 2 * c);
    or3 = 1'b1;
    @(posedge clk); #1;
    or3 = 1'b0;
    check("c3_drain", ov3, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    sum_in = 4'b0000; carry_in = 4'b1111;
    v3 = 1'b0; or3 = 1'b0; s3 = '0; c3 = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    // Release reset with in_valid already high: the next edge accepts.
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("first_accept", busy, 1);
    complete_op(0, 15, 0);

    run_op(15, 15, 5);
    run_op(0, 0, 0);
    run_op(8, 0, 1);

    // Asynchronous reset after three BUSY edges.
    @(negedge clk);
    sum_in = 4'hF; carry_in = 4'hF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk); rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      check("arst_discard", out_valid, 0);
    end
    run_op(1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    run_op3(5, 2);
    run_op3(0, 0);
    run_op3(15, 15);
    for (int i = 0; i < 20; i++) begin
      run_op3(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
